// File: rtl/fifo_sync_pkg.sv
// Shared word-size constants and data type for the lab datapath (FIFOs, inverter and loader).
package fifo_sync_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned ADDR_WIDTH_DEF = 4;

   typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage : fifo_sync_pkg

// File: rtl/fifo_ram.sv
// Register-array storage with one write port and one registered read port.
// Only the read register is reset; the array contents are not.
module fifo_ram #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned AddrWidth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] waddr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic                 re_i,
   input  logic [AddrWidth-1:0] raddr_i,
   output logic [DataWidth-1:0] rdata_o
);

   localparam int unsigned Depth = 2 ** AddrWidth;

   logic [DataWidth-1:0] mem_q [Depth];
   logic [DataWidth-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : fifo_ram

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data, occupancy count, level flags and
// sticky overflow/underflow error flags.
module fifo_sync
   import fifo_sync_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int unsigned AFULL_LEVEL = 14
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  WR,
   input  logic [DATA_WIDTH-1:0] DI,
   output logic                  Full,
   output logic                  AlmostFull,
   input  logic                  RD,
   output logic [DATA_WIDTH-1:0] DO,
   output logic                  Empty,
   output logic [ADDR_WIDTH:0]   Count,
   output logic                  Overflow,
   output logic                  Underflow,
   input  logic                  CLR_ERR
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(Depth);
   localparam logic [ADDR_WIDTH:0] AfullCnt = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] OneCnt   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] OnePtr = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  full, empty;
   logic                  wr_acc, rd_acc;

   // Flags decode the registered count only, so WR/RD never reach them combinationally.
   assign full   = (count_q == DepthCnt);
   assign empty  = (count_q == '0);
   assign wr_acc = WR & ~full;
   assign rd_acc = RD & ~empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_acc) begin
         wptr_d = wptr_q + OnePtr;
      end
      if (rd_acc) begin
         rptr_d = rptr_q + OnePtr;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + OneCnt;
         2'b01:   count_d = count_q - OneCnt;
         default: count_d = count_q;
      endcase
      // A new error in the same cycle as CLR_ERR keeps the flag set.
      ovf_d = (ovf_q & ~CLR_ERR) | (WR & full);
      udf_d = (udf_q & ~CLR_ERR) | (RD & empty);
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   fifo_ram #(
      .DataWidth (DATA_WIDTH),
      .AddrWidth (ADDR_WIDTH)
   ) u_ram (
      .clk_i   (CLK),
      .rst_ni  (RSTN),
      .we_i    (wr_acc),
      .waddr_i (wptr_q),
      .wdata_i (DI),
      .re_i    (rd_acc),
      .raddr_i (rptr_q),
      .rdata_o (DO)
   );

   assign Full       = full;
   assign Empty      = empty;
   assign AlmostFull = (count_q >= AfullCnt);
   assign Count      = count_q;
   assign Overflow   = ovf_q;
   assign Underflow  = udf_q;

endmodule : fifo_sync

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed boundary scenarios, randomized traffic against a
// queue-based reference model, and an upstream/inverter/downstream pipeline.
module tb_fifo_sync;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        WR, RD, CLR_ERR;
   logic [15:0] DI, DO;
   logic        Full, AlmostFull, Empty, Overflow, Underflow;
   logic [4:0]  Count;

   logic        WR2, RD2, CLR2;
   logic [15:0] DI2, DO2;
   logic        Full2, AlmostFull2, Empty2, Overflow2, Underflow2;
   logic [4:0]  Count2;

   int checks = 0;
   int failures = 0;

   logic [15:0] mq[$];
   logic [15:0] m_do;
   bit          m_ovf, m_udf;

   always #5 CLK = ~CLK;

   fifo_sync u_up (
      .CLK(CLK), .RSTN(RSTN), .WR(WR), .DI(DI), .Full(Full), .AlmostFull(AlmostFull),
      .RD(RD), .DO(DO), .Empty(Empty), .Count(Count), .Overflow(Overflow),
      .Underflow(Underflow), .CLR_ERR(CLR_ERR)
   );

   fifo_sync u_dn (
      .CLK(CLK), .RSTN(RSTN), .WR(WR2), .DI(DI2), .Full(Full2), .AlmostFull(AlmostFull2),
      .RD(RD2), .DO(DO2), .Empty(Empty2), .Count(Count2), .Overflow(Overflow2),
      .Underflow(Underflow2), .CLR_ERR(CLR2)
   );

   task automatic model_clear();
      mq.delete();
      m_do  = 16'h0000;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // One clock of upstream traffic; the model applies the access rules to the pre-edge state.
   task automatic cycle(input bit wr, input bit rd, input logic [15:0] di, input bit clr);
      bit was_full, was_empty;
      @(negedge CLK);
      WR = wr; RD = rd; DI = di; CLR_ERR = clr;
      @(posedge CLK);
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      if (rd && !was_empty) m_do = mq.pop_front();
      if (wr && !was_full) mq.push_back(di);
      m_ovf = (wr && was_full) || (m_ovf && !clr);
      m_udf = (rd && was_empty) || (m_udf && !clr);
      #1;
      WR = 1'b0; RD = 1'b0; CLR_ERR = 1'b0;
   endtask

   task automatic dn_cycle(input bit wr, input bit rd, input logic [15:0] di);
      @(negedge CLK);
      WR2 = wr; RD2 = rd; DI2 = di;
      @(posedge CLK);
      #1;
      WR2 = 1'b0; RD2 = 1'b0;
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      WR = 0; RD = 0; CLR_ERR = 0; DI = '0;
      WR2 = 0; RD2 = 0; CLR2 = 0; DI2 = '0;
      model_clear();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
      @(posedge CLK); #1;
      checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", Empty); end
      checks++; if (Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", Full); end
      checks++; if (Count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
      checks++; if (DO !== 16'h0000) begin failures++; $display("FAIL reset_do got=%h exp=0000", DO); end
      checks++;
      if (Overflow !== 1'b0 || Underflow !== 1'b0) begin
         failures++; $display("FAIL reset_err got=%b%b exp=00", Overflow, Underflow);
      end
   endtask

   task automatic test_single();
      cycle(1, 0, 16'hA5A5, 0);
      checks++; if (Empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", Empty); end
      checks++; if (Count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", Count); end
      cycle(0, 1, 16'h0000, 0);
      checks++; if (DO !== 16'hA5A5) begin failures++; $display("FAIL single_do got=%h exp=a5a5", DO); end
      checks++;
      if (Empty !== 1'b1 || Count !== 5'd0) begin
         failures++; $display("FAIL single_drain got=empty %b count %0d exp=empty 1 count 0", Empty, Count);
      end
   endtask

   task automatic test_fill_wrap();
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 16'(i), 0);
            checks++;
            if (AlmostFull !== (i + 1 >= 14) || Full !== (i + 1 == 16)) begin
               failures++;
               $display("FAIL fill_flags rep=%0d n=%0d got=af %b full %b", rep, i + 1, AlmostFull, Full);
            end
         end
         cycle(1, 0, 16'hFFFF, 0);
         checks++;
         if (Overflow !== 1'b1 || Count !== 5'd16) begin
            failures++; $display("FAIL fill_overflow got=ovf %b count %0d exp=ovf 1 count 16", Overflow, Count);
         end
         for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 16'h0000, 0);
            checks++;
            if (DO !== 16'(i)) begin failures++; $display("FAIL fill_order rep=%0d got=%h exp=%h", rep, DO, 16'(i)); end
         end
         checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%b exp=1", Empty); end
         cycle(0, 0, 16'h0000, 1);
         checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", Overflow); end
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 16; i++) cycle(1, 0, 16'(100 + i), 0);
      cycle(1, 1, 16'h1234, 0);
      checks++;
      if (Count !== 5'd15 || Overflow !== 1'b1 || DO !== 16'd100) begin
         failures++;
         $display("FAIL simul_full got=count %0d ovf %b do %h exp=15 1 0064", Count, Overflow, DO);
      end
      for (int i = 1; i < 16; i++) begin
         cycle(0, 1, 16'h0000, 0);
         checks++;
         if (DO !== 16'(100 + i)) begin failures++; $display("FAIL simul_order got=%h exp=%h", DO, 16'(100 + i)); end
      end
      cycle(1, 1, 16'h5678, 0);
      checks++;
      if (Count !== 5'd1 || Underflow !== 1'b1 || DO !== 16'd115) begin
         failures++;
         $display("FAIL simul_empty got=count %0d udf %b do %h exp=1 1 0073", Count, Underflow, DO);
      end
      cycle(0, 0, 16'h0000, 1);
      cycle(1, 0, 16'h0011, 0);
      cycle(1, 0, 16'h0022, 0);
      cycle(1, 1, 16'h0033, 0);
      checks++;
      if (Count !== 5'd3 || DO !== 16'h5678) begin
         failures++; $display("FAIL simul_mid got=count %0d do %h exp=3 5678", Count, DO);
      end
      cycle(0, 1, 16'h0000, 0);
      checks++; if (DO !== 16'h0011) begin failures++; $display("FAIL simul_mid_order1 got=%h exp=0011", DO); end
      cycle(0, 1, 16'h0000, 0);
      checks++; if (DO !== 16'h0022) begin failures++; $display("FAIL simul_mid_order2 got=%h exp=0022", DO); end
      cycle(0, 1, 16'h0000, 0);
      checks++; if (DO !== 16'h0033) begin failures++; $display("FAIL simul_mid_order3 got=%h exp=0033", DO); end
      checks++;
      if (Overflow !== 1'b0 || Underflow !== 1'b0) begin
         failures++; $display("FAIL simul_err got=%b%b exp=00", Overflow, Underflow);
      end
   endtask

   task automatic test_random();
      bit wr, rd, clr;
      for (int n = 0; n < 600; n++) begin
         // Bias toward writes in the first half and reads in the second to visit both ends.
         wr  = ($urandom_range(99) < ((n < 300) ? 65 : 35));
         rd  = ($urandom_range(99) < ((n < 300) ? 35 : 65));
         clr = ($urandom_range(15) == 0);
         cycle(wr, rd, 16'($urandom), clr);
         checks++;
         if (Count !== 5'(mq.size()) || Empty !== (mq.size() == 0) || Full !== (mq.size() == 16) ||
             AlmostFull !== (mq.size() >= 14)) begin
            failures++;
            $display("FAIL rand_level n=%0d got=count %0d e%b f%b af%b exp=count %0d", n, Count, Empty,
                     Full, AlmostFull, mq.size());
         end
         checks++;
         if (DO !== m_do || Overflow !== m_ovf || Underflow !== m_udf) begin
            failures++;
            $display("FAIL rand_data n=%0d got=do %h ovf %b udf %b exp=do %h ovf %b udf %b", n, DO,
                     Overflow, Underflow, m_do, m_ovf, m_udf);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) cycle(1, 0, 16'(16'hC000 + i), 0);
      cycle(0, 1, 16'h0000, 0);
      checks++; if (DO !== 16'hC000) begin failures++; $display("FAIL rstmid_pre got=%h exp=c000", DO); end
      @(negedge CLK);
      #2 RSTN = 1'b0;
      #1;
      checks++;
      if (Count !== 5'd0 || Empty !== 1'b1 || DO !== 16'h0000) begin
         failures++;
         $display("FAIL rstmid got=count %0d empty %b do %h exp=0 1 0000", Count, Empty, DO);
      end
      model_clear();
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   task automatic test_pipeline();
      logic [15:0] v;
      cycle(1, 0, 16'h00FF, 0);
      cycle(1, 0, 16'hF0F0, 0);
      for (int k = 0; k < 2; k++) begin
         cycle(0, 1, 16'h0000, 0);
         v = ~DO;
         dn_cycle(1, 0, v);
      end
      dn_cycle(0, 1, 16'h0000);
      checks++; if (DO2 !== 16'hFF00) begin failures++; $display("FAIL pipe_word0 got=%h exp=ff00", DO2); end
      dn_cycle(0, 1, 16'h0000);
      checks++; if (DO2 !== 16'h0F0F) begin failures++; $display("FAIL pipe_word1 got=%h exp=0f0f", DO2); end
      checks++;
      if (Empty !== 1'b1 || Empty2 !== 1'b1) begin
         failures++; $display("FAIL pipe_empty got=%b%b exp=11", Empty, Empty2);
      end
      checks++;
      if ({Overflow, Underflow, Overflow2, Underflow2} !== 4'b0000) begin
         failures++;
         $display("FAIL pipe_err got=%b%b%b%b exp=0000", Overflow, Underflow, Overflow2, Underflow2);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_wrap();
      test_simultaneous();
      test_random();
      test_reset_mid();
      test_pipeline();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_sync
